sample_rx_buffer: RTL

SAMPLE_RX_BUFFER -- requirements
Module: sample_rx_buffer

---
 rtl/sample_rx_buffer.sv | 100 ++++++++++
 1 files changed

// File: rtl/sample_rx_buffer.sv
// Frame capture buffer for strobed reference/error sample pairs. It counts N
// accepted strobes per frame into a small FIFO and flags overflow and strobe-rate violations.
module sample_rx_buffer #(
    parameter int BW_P  = 32,
    parameter int K     = 32,
    parameter int N     = 1024,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid_in,
    input  logic [BW_P-1:0]            up_in,
    input  logic [BW_P-1:0]            ep_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BW_P-1:0]            out_up,
    output logic [BW_P-1:0]            out_ep,
    output logic [$clog2(N+1)-1:0]     count,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       done,
    output logic                       overflow,
    output logic                       rate_err
);

    localparam int CW = $clog2(N+1);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);
    localparam int GW = $clog2(K+1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [2*BW_P-1:0]   mem [DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic [GW-1:0]       gap;
    logic                accepting, full, pop, push, drop, fast;
    logic [CW-1:0]       count_nxt;
    logic [LW-1:0]       level_nxt;

    // A full FIFO still takes a strobe when the head leaves in the same cycle.
    always_comb begin
        accepting = (state == IDLE) || (state == RUN);
        full      = (level == LW'(DEPTH));
        pop       = out_valid && out_ready;
        push      = valid_in && accepting && (!full || pop);
        drop      = valid_in && accepting && full && !pop;
        fast      = valid_in && accepting && (gap < GW'(K-1));
        count_nxt = count + CW'(push);
        level_nxt = level + LW'(push) - LW'(pop);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RUN: begin
                if (count_nxt == CW'(N))
                    state_nxt = (level_nxt == '0) ? DONE : DRAIN;
                else if (push)
                    state_nxt = RUN;
            end
            DRAIN:   if (level_nxt == '0) state_nxt = DONE;
            default: state_nxt = state;
        endcase
    end

    assign out_valid = (level != '0);
    assign out_up    = out_valid ? mem[rd_ptr][2*BW_P-1:BW_P] : '0;
    assign out_ep    = out_valid ? mem[rd_ptr][BW_P-1:0]      : '0;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {up_in, ep_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            level    <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            rate_err <= 1'b0;
            gap      <= GW'(K);
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == DONE);
            count <= count_nxt;
            level <= level_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (drop) overflow <= 1'b1;
            if (fast) rate_err <= 1'b1;
            // Gap saturates at K so the first strobe after reset is always legal.
            if (valid_in)            gap <= '0;
            else if (gap != GW'(K))  gap <= gap + GW'(1);
        end
    end

endmodule
